// File: rtl/i2s_tx.sv
// i2s_tx: I2S / left-justified / TDM audio serialiser clocked from clk32.
// The bit clock comes from a fractional phase accumulator, so the long-run
// frame rate is exact (edge jitter up to one clk32 period).
//
// Ports:
//   clk32        system clock
//   por          asynchronous active-high reset
//   en           synchronous serialiser enable
//   fmt          0 = I2S (one-bclk data delay), 1 = left-justified; taken at frame start
//   audio        CHANNELS packed samples, channel 0 in the LSBs
//   frame_start  one-cycle pulse in the cycle `audio` is latched
//   i2s_bclk     bit clock
//   i2s_lrck     word select / frame sync (high for the second half of the frame)
//   i2s_din      serial data, MSB first, samples zero-padded to SLOT_W
//   i2s_mclk     256*fs master clock, only when I2S_TX_MCLK_EN is defined
//
// Optional feature macro: I2S_TX_MCLK_EN adds the i2s_mclk port and its
// accumulator.
module i2s_tx #(
  parameter int CLK_HZ      = 32000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int CHANNELS    = 2,
  parameter int SAMPLE_W    = 16,
  parameter int SLOT_W      = 32
) (
  input  logic                         clk32,
  input  logic                         por,
  input  logic                         en,
  input  logic                         fmt,
  input  logic [CHANNELS*SAMPLE_W-1:0] audio,
  output logic                         frame_start,
  output logic                         i2s_bclk,
  output logic                         i2s_lrck,
  output logic                         i2s_din
`ifdef I2S_TX_MCLK_EN
  ,
  output logic                         i2s_mclk
`endif
);

  localparam int FRAME = CHANNELS * SLOT_W;
  localparam int BW    = $clog2(FRAME);
  localparam int AW    = $clog2(CLK_HZ) + 1;
  localparam int INC   = 2 * SAMPLE_RATE * FRAME;

  localparam logic [AW-1:0] INC_V = AW'(INC);
  localparam logic [AW-1:0] CLK_V = AW'(CLK_HZ);

  if (CHANNELS != 2 && CHANNELS != 4 && CHANNELS != 8) begin : g_bad_channels
    $error("i2s_tx: CHANNELS must be 2, 4 or 8");
  end
  if (SLOT_W < SAMPLE_W) begin : g_bad_slot
    $error("i2s_tx: SLOT_W must be >= SAMPLE_W");
  end
  if (longint'(4) * SAMPLE_RATE * FRAME > longint'(CLK_HZ)) begin : g_bad_rate
    $error("i2s_tx: bit clock exceeds CLK_HZ/4");
  end

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                       state;
  logic [AW-1:0]                acc;
  logic [BW-1:0]                b;
  logic [CHANNELS*SAMPLE_W-1:0] aud_l;
  logic                         fmt_l;
  logic                         lj_prev;

  logic [AW-1:0] acc_sum;
  logic          ovf;
  logic [BW-1:0] b_nxt;
  logic          lrck_nxt;
  logic          lj_first;
  logic          lj_next;

  // Left-justified data bit for frame bit index idx: slot = idx / SLOT_W,
  // position = idx % SLOT_W; positions past SAMPLE_W are padding zeros.
  function automatic logic lj_bit(input logic [BW-1:0] idx,
                                  input logic [CHANNELS*SAMPLE_W-1:0] aud);
    int unsigned slot;
    int unsigned pos;
    logic [CHANNELS*SAMPLE_W-1:0] sh;
    slot = 32'(idx) / SLOT_W;
    pos  = 32'(idx) % SLOT_W;
    sh   = '0;
    if (pos < SAMPLE_W) begin
      sh = aud >> (slot * SAMPLE_W + SAMPLE_W - 1 - pos);
    end
    return sh[0];
  endfunction

  always_comb begin
    acc_sum  = acc + INC_V;
    ovf      = (acc_sum >= CLK_V);
    b_nxt    = (b == BW'(FRAME - 1)) ? '0 : b + 1'b1;
    lrck_nxt = (32'(b_nxt) >= 32'(FRAME / 2));
    lj_first = lj_bit('0, audio);
    lj_next  = lj_bit(b_nxt, aud_l);
  end

  // lj_prev always tracks the left-justified bit of the current index, so in
  // I2S mode the delayed bit (including the wrap from the previous frame's
  // last slot into b = 0) is simply lj_prev.
  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      state       <= ST_IDLE;
      acc         <= '0;
      b           <= '0;
      aud_l       <= '0;
      fmt_l       <= 1'b0;
      lj_prev     <= 1'b0;
      frame_start <= 1'b0;
      i2s_bclk    <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_din     <= 1'b0;
    end else if (!en) begin
      state       <= ST_IDLE;
      acc         <= '0;
      b           <= '0;
      lj_prev     <= 1'b0;
      frame_start <= 1'b0;
      i2s_bclk    <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_din     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // First enabled cycle: latch and start a fresh frame at b = 0.
          // The accumulator already advances; INC <= CLK_HZ/2 so no toggle yet.
          state       <= ST_RUN;
          acc         <= INC_V;
          b           <= '0;
          aud_l       <= audio;
          fmt_l       <= fmt;
          frame_start <= 1'b1;
          i2s_bclk    <= 1'b0;
          i2s_lrck    <= 1'b0;
          lj_prev     <= lj_first;
          i2s_din     <= fmt ? lj_first : 1'b0;
        end
        ST_RUN: begin
          frame_start <= 1'b0;
          if (ovf) begin
            acc      <= acc_sum - CLK_V;
            i2s_bclk <= ~i2s_bclk;
            if (i2s_bclk) begin
              b        <= b_nxt;
              i2s_lrck <= lrck_nxt;
              if (b_nxt == '0) begin
                aud_l       <= audio;
                fmt_l       <= fmt;
                frame_start <= 1'b1;
                lj_prev     <= lj_first;
                i2s_din     <= fmt ? lj_first : lj_prev;
              end else begin
                lj_prev <= lj_next;
                i2s_din <= fmt_l ? lj_next : lj_prev;
              end
            end
          end else begin
            acc <= acc_sum;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef I2S_TX_MCLK_EN
  localparam int            INC_M   = 512 * SAMPLE_RATE;
  localparam logic [AW-1:0] INC_M_V = AW'(INC_M);

  if (longint'(INC_M) > longint'(CLK_HZ)) begin : g_bad_mclk
    $error("i2s_tx: 512*SAMPLE_RATE exceeds CLK_HZ");
  end

  logic [AW-1:0] acc_m;
  logic [AW-1:0] acc_m_sum;

  always_comb begin
    acc_m_sum = acc_m + INC_M_V;
  end

  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      acc_m    <= '0;
      i2s_mclk <= 1'b0;
    end else if (!en) begin
      acc_m    <= '0;
      i2s_mclk <= 1'b0;
    end else if (acc_m_sum >= CLK_V) begin
      acc_m    <= acc_m_sum - CLK_V;
      i2s_mclk <= ~i2s_mclk;
    end else begin
      acc_m <= acc_m_sum;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: a default stereo instance (A) with a scoreboard fed at
// each frame_start, and a 4-channel 16-bit-slot TDM instance (B).
module tb_i2s_tx;

  logic        clk32 = 1'b0;
  logic        por;
  logic        a_en, b_en, a_fmt, b_fmt;
  logic [31:0] a_audio;
  logic [63:0] b_audio;
  logic        a_fs, a_bclk, a_lrck, a_din;
  logic        b_fs, b_bclk, b_lrck, b_din;
`ifdef I2S_TX_MCLK_EN
  logic        a_mclk, b_mclk;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk32 = ~clk32;

  i2s_tx #(.CLK_HZ(32000000), .SAMPLE_RATE(48000), .CHANNELS(2),
           .SAMPLE_W(16), .SLOT_W(32)) u_a (
    .clk32(clk32), .por(por), .en(a_en), .fmt(a_fmt), .audio(a_audio),
    .frame_start(a_fs), .i2s_bclk(a_bclk), .i2s_lrck(a_lrck), .i2s_din(a_din)
`ifdef I2S_TX_MCLK_EN
    , .i2s_mclk(a_mclk)
`endif
  );

  i2s_tx #(.CLK_HZ(32000000), .SAMPLE_RATE(48000), .CHANNELS(4),
           .SAMPLE_W(16), .SLOT_W(16)) u_b (
    .clk32(clk32), .por(por), .en(b_en), .fmt(b_fmt), .audio(b_audio),
    .frame_start(b_fs), .i2s_bclk(b_bclk), .i2s_lrck(b_lrck), .i2s_din(b_din)
`ifdef I2S_TX_MCLK_EN
    , .i2s_mclk(b_mclk)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp, input int unsigned tol = 0);
    logic [63:0] d;
    n_chk++;
    d = (got > exp) ? got - exp : exp - got;
    if (!$isunknown(got) && d <= 64'(tol)) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (tol %0d)", tag, got, exp, tol);
  endtask

  // Scoreboard for instance A: one {lrck, din} entry per bclk rise.
  logic [1:0]  sbq[$];
  logic        sb_on = 1'b0;
  logic        sb_prev_last = 1'b0;
  logic        a_bclk_q = 1'b0;
  logic [31:0] smp_aud = '0;
  logic        smp_fmt = 1'b0;

  // Stimulus as seen at each rising edge (what the DUT latches).
  always @(posedge clk32) begin
    smp_aud <= a_audio;
    smp_fmt <= a_fmt;
  end

  task automatic push_frame(input logic [31:0] aud, input logic f);
    logic [31:0] sh;
    logic        bitv, prevb;
    prevb = sb_prev_last;
    for (int i = 0; i < 64; i++) begin
      int s, p;
      s = i / 32;
      p = i % 32;
      bitv = 1'b0;
      if (p < 16) begin
        sh   = aud >> (s * 16 + 15 - p);
        bitv = sh[0];
      end
      sbq.push_back({(i >= 32), f ? bitv : prevb});
      prevb = bitv;
    end
    sb_prev_last = prevb;
  endtask

  always @(negedge clk32) begin
    logic [1:0] e;
    if (sb_on) begin
      if (a_fs) push_frame(smp_aud, smp_fmt);
      if (a_bclk && !a_bclk_q) begin
        if (sbq.size() == 0) check("sb_underrun", 1, 0);
        else begin
          e = sbq.pop_front();
          check("sb_bit", {a_lrck, a_din}, e);
        end
      end
    end else begin
      sbq.delete();
      sb_prev_last = 1'b0;
    end
    a_bclk_q <= a_bclk;
  end

  task automatic wait_fs(input bit sel);
    int unsigned cyc = 0;
    logic hit = 1'b0;
    while (!hit && cyc < 2000) begin
      @(negedge clk32);
      cyc++;
      hit = sel ? b_fs : a_fs;
    end
    if (!hit) check("fs_timeout", 0, 1);
  endtask

  task automatic wait_falls_a(input int unsigned n);
    int unsigned cyc = 0, k = 0;
    logic prev;
    prev = a_bclk;
    while (k < n && cyc < 5000) begin
      @(negedge clk32);
      cyc++;
      if (prev && !a_bclk) k++;
      prev = a_bclk;
    end
    if (k < n) check("falls_timeout", k, n);
  endtask

  task automatic cap64(input bit sel, output logic [63:0] dv, output logic [63:0] lv);
    int unsigned n = 0, cyc = 0;
    logic prev, cur;
    dv = '0;
    lv = '0;
    prev = sel ? b_bclk : a_bclk;
    while (n < 64 && cyc < 20000) begin
      @(negedge clk32);
      cyc++;
      cur = sel ? b_bclk : a_bclk;
      if (cur && !prev) begin
        dv = {dv[62:0], sel ? b_din : a_din};
        lv = {lv[62:0], sel ? b_lrck : a_lrck};
        n++;
      end
      prev = cur;
    end
    if (n < 64) check("cap_timeout", n, 64);
  endtask

  localparam logic [63:0] LJ_PAT  = 64'h8001_0000_7FFE_0000;
  localparam logic [63:0] I2S_PAT = 64'h4000_8000_3FFF_0000;
  localparam logic [63:0] LR_PAT  = 64'h0000_0000_FFFF_FFFF;

  initial begin
    logic [63:0] dv, lv;
    int unsigned ra, rb, nf, rm;
    logic pa, pb, pm;

    por = 1'b1; a_en = 1'b0; b_en = 1'b0; a_fmt = 1'b1; b_fmt = 1'b1;
    a_audio = '0; b_audio = '0;
    repeat (3) @(negedge clk32);
    check("rst_bclk", a_bclk, 0);
    check("rst_lrck", a_lrck, 0);
    check("rst_din", a_din, 0);
    check("rst_fs", a_fs, 0);
    check("rst_b_bclk", b_bclk, 0);
`ifdef I2S_TX_MCLK_EN
    check("rst_mclk", a_mclk, 0);
`endif
    por = 1'b0;
    repeat (4) @(negedge clk32);
    check("idle_bclk", a_bclk, 0);
    check("idle_fs", a_fs, 0);
`ifdef I2S_TX_MCLK_EN
    check("idle_mclk", a_mclk, 0);
`endif

    // Rate over 1 ms, scoreboard running with random data and format.
    a_audio = $urandom;
    b_audio = {$urandom, $urandom};
    sb_on = 1'b1;
    a_en = 1'b1;
    b_en = 1'b1;
    ra = 0; rb = 0; nf = 0; rm = 0; pa = 1'b0; pb = 1'b0; pm = 1'b0;
    for (int unsigned c = 0; c < 32000; c++) begin
      @(negedge clk32);
      if (a_bclk && !pa) ra++;
      if (b_bclk && !pb) rb++;
      pa = a_bclk;
      pb = b_bclk;
      nf += a_fs;
`ifdef I2S_TX_MCLK_EN
      if (a_mclk && !pm) rm++;
      pm = a_mclk;
`endif
      if (c % 53 == 52) begin
        a_audio = $urandom;
        a_fmt   = 1'($urandom_range(0, 1));
      end
    end
    sb_on = 1'b0;
    check("rate_bclk_a", ra, 3072, 1);
    check("rate_bclk_tdm", rb, 3072, 1);
    check("rate_frames", nf, 48, 1);
`ifdef I2S_TX_MCLK_EN
    check("rate_mclk", rm, 12288, 1);
`endif

    // LJ pattern from a fresh enable; audio changes mid-frame are ignored.
    a_en = 1'b0;
    b_en = 1'b0;
    repeat (3) @(negedge clk32);
    a_audio = {16'h7FFE, 16'h8001};
    a_fmt = 1'b1;
    a_en = 1'b1;
    @(negedge clk32);
    check("en_fs", a_fs, 1);
    check("en_din_msb", a_din, 1);
    a_audio = $urandom;
    cap64(0, dv, lv);
    check("lj_data", dv, LJ_PAT);
    check("lj_lrck", lv, LR_PAT);
    a_audio = {16'h7FFE, 16'h8001};

    // Drop en at b = 20 while bclk is high.
    wait_fs(0);
    wait_falls_a(20);
    while (!a_bclk) @(negedge clk32);
    check("drop_pre_bclk", a_bclk, 1);
    a_en = 1'b0;
    @(negedge clk32);
    check("drop_bclk", a_bclk, 0);
    check("drop_lrck", a_lrck, 0);
    check("drop_din", a_din, 0);
`ifdef I2S_TX_MCLK_EN
    check("drop_mclk", a_mclk, 0);
`endif
    repeat (5) @(negedge clk32);
    check("off_fs", a_fs, 0);
    a_en = 1'b1;
    @(negedge clk32);
    check("reen_fs", a_fs, 1);
    check("reen_din", a_din, 1);
    cap64(0, dv, lv);
    check("reen_data", dv, LJ_PAT);

    // por mid-frame while lrck is high.
    wait_fs(0);
    wait_falls_a(40);
    check("por_pre_lrck", a_lrck, 1);
    #2 por = 1'b1;
    #1;
    check("por_lrck", a_lrck, 0);
    check("por_bclk", a_bclk, 0);
    check("por_din", a_din, 0);
    @(negedge clk32);
    por = 1'b0;
    @(negedge clk32);
    check("por_rel_fs", a_fs, 1);
    // fmt change mid-frame must not affect the frame in flight.
    a_fmt = 1'b0;
    cap64(0, dv, lv);
    check("por_rel_data", dv, LJ_PAT);

    // I2S: one-bclk delay behind lrck.
    wait_fs(0);
    cap64(0, dv, lv);
    check("i2s_data", dv, I2S_PAT);
    check("i2s_lrck", lv, LR_PAT);

    // TDM, 4 x 16-bit slots.
    b_audio = 64'h4444_3333_2222_1111;
    b_fmt = 1'b1;
    b_en = 1'b1;
    wait_fs(1);
    cap64(1, dv, lv);
    check("tdm_data", dv, 64'h1111_2222_3333_4444);
    check("tdm_lrck", lv, LR_PAT);
    // I2S wrap: slot 3 LSB (1) reappears at b = 0 of the next frame.
    b_audio = 64'h4445_3333_2222_1111;
    b_fmt = 1'b0;
    wait_fs(1);
    wait_fs(1);
    cap64(1, dv, lv);
    check("tdm_i2s_data", dv, 64'h8888_9111_1999_A222);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Parametrised I2S/TDM audio serialiser driven from the 32 MHz system clock. It replaces the fixed integer-divider bit clock with a fractional phase accumulator, so the long-run sample rate is exact. It supports a configurable channel count, sample width and slot width, and runs in either I2S or left-justified format. It sits in the board toplevel between the core's parallel audio output and the external I2S DAC pins.

## Interface

Parameters:
- CLK_HZ, 32000000, system clock frequency in Hz
- SAMPLE_RATE, 48000, frame rate fs in Hz
- CHANNELS, 2, slots per frame; legal values 2, 4, 8
- SAMPLE_W, 16, bits per sample, MSB first
- SLOT_W, 32, bits per slot; must be ≥ SAMPLE_W, and samples are zero-padded at the LSB end
- Legality: 2·SAMPLE_RATE·CHANNELS·SLOT_W·2 ≤ CLK_HZ, i.e. bclk ≤ CLK_HZ/4; an elaboration error is raised otherwise

Ports:
- clk32  in  1  system clock
- por  in  1  asynchronous active-high reset
- en  in  1  serialiser enable, synchronous
- fmt  in  1  0 = I2S (one-bclk data delay), 1 = left-justified; sampled only at frame start
- audio  in  CHANNELS·SAMPLE_W  packed samples; channel 0 occupies the LSBs
- frame_start  out  1  one-cycle pulse when `audio` is latched
- i2s_bclk  out  1  bit clock
- i2s_lrck  out  1  word select / frame sync
- i2s_din  out  1  serial data to DAC
- i2s_mclk  out  1  master clock; present only with I2S_TX_MCLK_EN

## Operation

- FRAME = CHANNELS·SLOT_W. Bit index b runs 0..FRAME-1 in a counter of width clog2(FRAME).
- Bit-clock accumulator:
  - INC = 2·SAMPLE_RATE·FRAME; acc width is clog2(CLK_HZ)+1.
  - Each cycle: if acc+INC ≥ CLK_HZ, then acc ← acc+INC−CLK_HZ and bclk toggles; otherwise acc ← acc+INC.
  - The long-run rate is exact; edge jitter is ≤ 1 clk32 period.
- Falling edge of bclk (toggle from 1 to 0):
  - b ← b+1 mod FRAME.
  - lrck and din update in the same clk32 cycle.
- lrck = (b ≥ FRAME/2). For CHANNELS > 2 this gives a TDM-style 50 % frame sync.
- Slot mapping: slot s = b / SLOT_W, bit position p = b mod SLOT_W.
  - The LJ data bit is audio_latched[s] bit (SAMPLE_W−1−p) for p < SAMPLE_W, else 0.
- Formats:
  - LJ: din = LJ data bit for b.
  - I2S: din = LJ data bit for b−1. At b = 0 the bit comes from the previous frame's last slot, held in a one-bit delay register.
- Latch: on the falling edge where b wraps to 0:
  - `audio` and `fmt` are captured.
  - frame_start pulses for exactly one cycle.
- Enable:
  - en low: acc, b, bclk, lrck and din are held at 0; frame_start stays 0.
  - en rising, first cycle with en = 1: latch, frame_start pulse, b = 0. din = ch0 MSB in LJ mode, 0 in I2S mode. The first bclk rise follows the first accumulator overflow.
  - en falling mid-frame: all outputs are 0 in the next cycle. The partial frame is abandoned and never resumed.

## Timing

- Reset values: acc 0, b 0, and all outputs 0, including i2s_mclk.
- por is asynchronous. Asserting it mid-frame forces all outputs to 0 immediately. After release, operation restarts as for an en rising edge, if en is high.
- Latency:
  - `audio` is sampled at the frame_start cycle.
  - Its ch0 MSB is on din the same cycle (LJ) or one bclk later (I2S).
  - din, lrck and bclk are registered; no combinational path from inputs to outputs.
- Changes to `audio` between latches have no effect on the current frame.
- fmt changes take effect only at the next frame boundary.
- Data and lrck change only on falling bclk edges. The DAC samples on rising edges with at least 1 clk32 of setup.

## Configuration

- I2S_TX_MCLK_EN defined:
  - Adds a second accumulator with INC_M = 2·256·SAMPLE_RATE that toggles i2s_mclk (256·fs, exact long-run rate, ≤ 1-cycle jitter).
  - Requires 512·SAMPLE_RATE ≤ CLK_HZ.
  - i2s_mclk is held at 0 while en is low or por is high.
- I2S_TX_MCLK_EN undefined: the i2s_mclk port and its accumulator are absent.

## Test plan

- Rate: defaults, en = 1, run 32000 clk32 cycles (1 ms) → 3072 ± 1 bclk rising edges and exactly 48 frame_start pulses ± 1.
- LJ pattern: fmt = 1, left 0x8001, right 0x7FFE; capture din on bclk rises → 1000000000000001 followed by 16 zeros, then 0111111111111110 followed by 16 zeros; lrck 0 for the first 32 bits and 1 for the next 32.
- I2S delay: same data, fmt = 0 → left MSB appears 1 bclk after lrck falls; right LSB is emitted at b = 0 of the following frame.
- TDM: CHANNELS = 4, SLOT_W = 16, values 0x1111, 0x2222, 0x3333, 0x4444 → slot order 0 to 3 matches; lrck high for slots 2–3; bclk is 3.072 MHz average.
- Enable / reset mid-frame: drop en at b = 20 → next cycle bclk, lrck and din = 0; re-raise en → frame_start pulse in that cycle and frame restarts at b = 0. Repeat with por asserted → outputs 0 asynchronously.
- With I2S_TX_MCLK_EN, 32000 cycles → 12288 ± 1 i2s_mclk rising edges; mclk is 0 while en = 0.
